// File: rtl/dijkstra_path_backtrace.sv
// Walks the Dijkstra predecessor chain from target back to source onto a stack,
// then streams the path source-first over valid/ready with its cost and hop count.
module dijkstra_path_backtrace #(
    parameter int          MAX_NODES = 15,
    parameter logic [13:0] INF_DIST  = 14'h3FFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [8:0]                 start_id,
    input  logic [8:0]                 target_id,
    input  logic [MAX_NODES-1:0][13:0] distance,
    input  logic [MAX_NODES-1:0][8:0]  neighbour,
    output logic [8:0]                 path_node,
    output logic                       path_valid,
    input  logic                       path_ready,
    output logic                       path_last,
    output logic [8:0]                 path_length,
    output logic [13:0]                total_distance,
    output logic                       in_progress,
    output logic                       finished,
    output logic                       error
);

    localparam int               SPW      = $clog2(MAX_NODES + 1);
    localparam logic [8:0]       MAX_ID   = 9'(MAX_NODES);
    localparam logic [SPW-1:0]   SP_LIMIT = SPW'(MAX_NODES - 2);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_TRACE = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t         state_r, state_s;
    logic [8:0]     src_r, src_s;
    logic [8:0]     tgt_r, tgt_s;
    logic [8:0]     cur_r, cur_s;
    logic [SPW-1:0] sp_r, sp_s;
    logic [8:0]     stack_r [MAX_NODES];
    logic           push_s;

    logic [8:0]     path_node_s;
    logic           path_last_s;
    logic [8:0]     path_length_s;
    logic [13:0]    total_distance_s;
    logic           error_s;

    logic [13:0]    dist_tgt_s;
    logic [8:0]     nbr_cur_s;
    logic           check_fail_s;
    logic           trace_fail_s;
    logic           beat_s;
    logic [SPW-1:0] pop_idx_s;

    // Array lookups by latched target and current node; out-of-range ids read as zero.
    always_comb begin
        dist_tgt_s = 14'd0;
        nbr_cur_s  = 9'd0;
        for (int i = 0; i < MAX_NODES; i++) begin
            dist_tgt_s = (tgt_r == 9'(i)) ? distance[i]  : dist_tgt_s;
            nbr_cur_s  = (cur_r == 9'(i)) ? neighbour[i] : nbr_cur_s;
        end
    end

    assign check_fail_s = (src_r >= MAX_ID) || (tgt_r >= MAX_ID) || (dist_tgt_s == INF_DIST);
    // A chain that has not reached the source before the stack is nearly full is cyclic or too long.
    assign trace_fail_s = (nbr_cur_s >= MAX_ID) || (sp_r == SP_LIMIT);
    assign beat_s       = path_valid && path_ready;
    assign pop_idx_s    = sp_r - SPW'(2);

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_CHECK;
                else       state_s = S_IDLE;
            end
            S_CHECK: begin
                if (check_fail_s) state_s = S_ERR;
                else              state_s = S_TRACE;
            end
            S_TRACE: begin
                if (cur_r == src_r)    state_s = S_EMIT;
                else if (trace_fail_s) state_s = S_ERR;
                else                   state_s = S_TRACE;
            end
            S_EMIT: begin
                if (beat_s && path_last) state_s = S_DONE;
                else                     state_s = S_EMIT;
            end
            S_DONE:  state_s = S_IDLE;
            S_ERR:   state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath and next values of the registered outputs.
    always_comb begin
        src_s            = src_r;
        tgt_s            = tgt_r;
        cur_s            = cur_r;
        sp_s             = sp_r;
        push_s           = 1'b0;
        path_node_s      = path_node;
        path_last_s      = path_last;
        path_length_s    = path_length;
        total_distance_s = total_distance;
        error_s          = error;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    src_s            = start_id;
                    tgt_s            = target_id;
                    error_s          = 1'b0;
                    path_length_s    = 9'd0;
                    total_distance_s = 14'd0;
                end else begin
                    src_s = src_r;
                end
            end
            S_CHECK: begin
                cur_s = tgt_r;
                sp_s  = '0;
                if (check_fail_s) error_s = 1'b1;
                else              error_s = error;
            end
            S_TRACE: begin
                push_s = 1'b1;
                sp_s   = sp_r + SPW'(1);
                if (cur_r == src_r) begin
                    path_length_s    = 9'(sp_r) + 9'd1;
                    total_distance_s = dist_tgt_s;
                    path_node_s      = cur_r;
                    path_last_s      = (sp_r == '0);
                end else if (trace_fail_s) begin
                    error_s = 1'b1;
                end else begin
                    cur_s = nbr_cur_s;
                end
            end
            S_EMIT: begin
                if (beat_s) begin
                    sp_s = sp_r - SPW'(1);
                    if (path_last) begin
                        path_last_s = 1'b0;
                    end else begin
                        path_node_s = stack_r[pop_idx_s];
                        path_last_s = (sp_r == SPW'(2));
                    end
                end else begin
                    sp_s = sp_r;
                end
            end
            default: begin
                sp_s = sp_r;
            end
        endcase
    end

    // State, control and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= S_IDLE;
            src_r          <= 9'd0;
            tgt_r          <= 9'd0;
            cur_r          <= 9'd0;
            sp_r           <= '0;
            path_node      <= 9'd0;
            path_valid     <= 1'b0;
            path_last      <= 1'b0;
            path_length    <= 9'd0;
            total_distance <= 14'd0;
            in_progress    <= 1'b0;
            finished       <= 1'b0;
            error          <= 1'b0;
        end else begin
            state_r        <= state_s;
            src_r          <= src_s;
            tgt_r          <= tgt_s;
            cur_r          <= cur_s;
            sp_r           <= sp_s;
            path_node      <= path_node_s;
            path_valid     <= (state_s == S_EMIT);
            path_last      <= path_last_s;
            path_length    <= path_length_s;
            total_distance <= total_distance_s;
            in_progress    <= (state_s != S_IDLE);
            finished       <= (state_s == S_DONE) || (state_s == S_ERR);
            error          <= error_s;
        end
    end

    // Path stack storage; contents are only meaningful below the stack pointer.
    always_ff @(posedge clk) begin
        if (push_s) begin
            stack_r[sp_r] <= cur_r;
        end
    end

endmodule

// File: doc/dijkstra_path_backtrace.md
Name: dijkstra_path_backtrace

Overview:
- Downstream consumer of the Dijkstra main-loop stage.
- Takes the final distance and predecessor (neighbour) arrays, plus a target node id.
- Walks the predecessor chain from target back to the source, stacking the nodes.
- Streams the path out in forward order (source first) over a valid/ready interface, with total cost and hop count, toward the cart's navigation/HPS bridge.

Parameters:
- MAX_NODES, 15, number of graph nodes; sizes the input arrays and the path stack.
- INF_DIST, 14'h3FFF, distance value meaning "unreachable".

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; begin a backtrace (ignored unless IDLE).
- start_id  input  9  source node id used by the Dijkstra run.
- target_id  input  9  destination node id.
- distance  input  14 x MAX_NODES  final distance per node; held stable from start until finished.
- neighbour  input  9 x MAX_NODES  predecessor per node; held stable from start until finished.
- path_node  output  9  current path node id (source first).
- path_valid  output  1  path_node is valid.
- path_ready  input  1  consumer accepts path_node.
- path_last  output  1  marks the target node (final beat).
- path_length  output  9  number of nodes in the path; valid from EMIT entry until next start.
- total_distance  output  14  distance[target_id]; valid from EMIT entry until next start.
- in_progress  output  1  high in every state except IDLE.
- finished  output  1  one-cycle pulse on completion (success or error).
- error  output  1  sticky until the next accepted start.

Behaviour:
- Reset (synchronous, active-high, any state): state=IDLE, stack pointer=0, all outputs 0. This also aborts a trace or emission mid-stream.
- All outputs are registered.
- States: IDLE, CHECK, TRACE, EMIT, DONE, ERR.
- IDLE:
  - On start=1, latch start_id and target_id, clear error, go to CHECK.
  - start while not IDLE is ignored.
- CHECK (1 cycle): error if start_id>=MAX_NODES, target_id>=MAX_NODES, or distance[target_id]==INF_DIST → ERR. Otherwise set cur=target_id, sp=0 → TRACE.
- TRACE (one node per cycle):
  - Push cur (stack[sp]=cur, sp++).
  - If cur==start_id, go to EMIT with path_length=sp+1 and total_distance=distance[target_id].
  - Else if neighbour[cur]>=MAX_NODES, or sp+1==MAX_NODES with cur!=start_id (chain too long or cyclic) → ERR.
  - Else cur=neighbour[cur].
- Latency: a k-node path spends k cycles in TRACE; the first path_valid appears k+2 cycles after start.
- EMIT:
  - path_valid=1 and path_node=stack[sp-1] (pops in LIFO order, so source first).
  - On path_valid&&path_ready, sp--.
  - path_last=1 when sp==1.
  - path_node and path_valid stay stable while path_ready=0.
  - The handshake with path_last → DONE, and path_valid drops the next cycle.
  - Zero-bubble: back-to-back beats when path_ready is held high.
- DONE: finished=1 for one cycle → IDLE.
- ERR: error=1 (held), finished=1 for one cycle, path_valid never asserted → IDLE.
- start_id==target_id (reachable): path_length=1, single beat with path_last=1, total_distance=distance[start_id] (normally 0).
- path_length never exceeds MAX_NODES. The stack is MAX_NODES entries of 9 bits.
- No arithmetic on distances: total_distance is a straight copy.

Test Plan:
- Line graph 0→1→2→3 (neighbour[3]=2, [2]=1, [1]=0), distance[3]=30, start_id=0, target_id=3, path_ready=1 → beats 0,1,2,3 on consecutive cycles. path_last on 3, path_length=4, total_distance=30, finished pulses once, error=0.
- start_id=target_id=5, distance[5]=0 → single beat 5 with path_last=1, path_length=1, total_distance=0.
- Same line graph with path_ready toggling 1,0,0,1,0,1… → each node delivered exactly once and in order. path_node/path_valid stable during stalls.
- distance[7]=14'h3FFF, target_id=7 → no path_valid; error=1 and finished pulse 2 cycles after start. error clears on the next start.
- Cyclic predecessors neighbour[4]=6, [6]=4, target_id=4, start_id=0, distance finite → ERR after MAX_NODES-1 TRACE cycles, no beats. Also target_id=20 → ERR directly from CHECK.
- Assert reset during EMIT after 2 beats → next cycle path_valid=0, in_progress=0. A new start replays the full path from the source.
